// File: rtl/axis_line_conditioner_pkg.sv
// Shared video constants and the line-conditioner state encoding.
package axis_line_conditioner_pkg;

  localparam int VID_DATA_WIDTH = 24;
  localparam int VID_H_ACTIVE   = 1280;
  localparam int VID_V_ACTIVE   = 720;

  typedef enum logic [1:0] {
    SEEK_SOF = 2'd0,
    PASS     = 2'd1,
    PAD      = 2'd2,
    DROP     = 2'd3
  } lc_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register: holds its beat until downstream takes it.
module axis_reg_slice #(
  parameter int WIDTH = 26
) (
  input  logic             video_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load a new beat whenever the stage is empty or being emptied this cycle.
  always_ff @(posedge video_clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/axis_line_conditioner.sv
// Forces a VDMA pixel stream into exact H_ACTIVE x V_ACTIVE frames.
//
//   state    | meaning
//   SEEK_SOF | discard input until the first TUSER beat
//   PASS     | forward input beats, regenerate TUSER/TLAST
//   PAD      | input stalled, fill the rest of the line with PAD_PIXEL
//   DROP     | line already complete, discard input through its TLAST
//
// h_cnt/v_cnt hold the position of the next beat entering the output stage.
module axis_line_conditioner
  import axis_line_conditioner_pkg::*;
#(
  parameter int                    DATA_WIDTH = VID_DATA_WIDTH,
  parameter int                    H_ACTIVE   = VID_H_ACTIVE,
  parameter int                    V_ACTIVE   = VID_V_ACTIVE,
  parameter logic [DATA_WIDTH-1:0] PAD_PIXEL  = '0
) (
  input  logic                  video_clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  locked,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_sof
);

  localparam int HW = $clog2(H_ACTIVE);
  localparam int VW = $clog2(V_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);

  logic            rst_meta_n, rst_sync_n;
  lc_state_e       state, state_nxt;
  logic [HW-1:0]   h_cnt, h_nxt;
  logic [VW-1:0]   v_cnt, v_nxt;
  logic            restart, restart_nxt;
  logic            slot, load, take, force_v0, ready_c;
  logic            at_origin, at_eol;
  logic            e_short, e_long, e_sof;
  logic [DATA_WIDTH-1:0] ld_data;

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign at_eol    = (h_cnt == H_LAST);

  // Reset asserts immediately, releases two video_clk edges later.
  always_ff @(posedge video_clk or negedge resetn) begin
    if (!resetn) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  // Next state, input ready, output-stage load and error detection.
  always_comb begin
    state_nxt   = state;
    restart_nxt = restart;
    ready_c     = 1'b0;
    take        = 1'b0;
    load        = 1'b0;
    force_v0    = 1'b0;
    ld_data     = s_axis_tdata;
    e_short     = 1'b0;
    e_long      = 1'b0;
    e_sof       = 1'b0;
    case (state)
      SEEK_SOF: begin
        ready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tuser) take = 1'b1;
      end
      PASS: begin
        // A misplaced TUSER is held on the input until the frame is realigned.
        if (s_axis_tuser && !at_origin) begin
          if (s_axis_tvalid) begin
            e_sof = 1'b1;
            if (h_cnt == '0) begin
              force_v0 = 1'b1;
            end else begin
              state_nxt   = PAD;
              restart_nxt = 1'b1;
            end
          end
        end else begin
          ready_c = slot;
          if (s_axis_tvalid && slot) begin
            take = 1'b1;
            if (at_origin && !s_axis_tuser) e_sof = 1'b1;
          end
        end
      end
      PAD: begin
        ld_data = PAD_PIXEL;
        load    = slot;
        if (slot && at_eol) begin
          state_nxt   = PASS;
          restart_nxt = 1'b0;
        end
      end
      DROP: begin
        ready_c = !s_axis_tuser;
        if (s_axis_tvalid && (s_axis_tuser || s_axis_tlast)) state_nxt = PASS;
      end
      default: state_nxt = SEEK_SOF;
    endcase
    if (take) begin
      load = 1'b1;
      if (at_eol && !s_axis_tlast) begin
        e_long    = 1'b1;
        state_nxt = DROP;
      end else if (!at_eol && s_axis_tlast) begin
        e_short   = 1'b1;
        state_nxt = PAD;
      end else begin
        state_nxt = PASS;
      end
    end
  end

  // Position of the next output beat; a frame restart pins the line to 0.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (load) begin
      h_nxt = at_eol ? '0 : h_cnt + 1'b1;
      if (at_eol) v_nxt = (restart || v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    if (force_v0) v_nxt = '0;
  end

  // State, counters and registered error pulses.
  always_ff @(posedge video_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= SEEK_SOF;
      h_cnt     <= '0;
      v_cnt     <= '0;
      restart   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_sof   <= 1'b0;
    end else begin
      state     <= state_nxt;
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      restart   <= restart_nxt;
      err_short <= e_short;
      err_long  <= e_long;
      err_sof   <= e_sof;
    end
  end

  assign s_axis_tready = ready_c & rst_sync_n;
  assign locked        = (state != SEEK_SOF);

  axis_reg_slice #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_out_reg (
    .video_clk (video_clk),
    .resetn    (rst_sync_n),
    .in_data   ({at_origin, at_eol, ld_data}),
    .in_valid  (load),
    .in_ready  (slot),
    .out_data  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_line_conditioner.sv
// Scoreboard bench for axis_line_conditioner with a line-level reference model.
module tb_axis_line_conditioner;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;
  localparam logic [DW-1:0] PADV = 24'hFFFFFF;

  logic          video_clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic          locked, err_short, err_long, err_sof;

  always #5 video_clk = ~video_clk;

  axis_line_conditioner #(
    .DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .PAD_PIXEL(PADV)
  ) dut (
    .video_clk(video_clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .locked(locked), .err_short(err_short), .err_long(err_long), .err_sof(err_sof)
  );

  int n_cmp = 0, n_fail = 0;
  logic [DW+1:0] exp_q[$];
  bit mon_en = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;
  int exp_short = 0, exp_long = 0, exp_sof = 0;
  int got_short = 0, got_long = 0, got_sof = 0;
  bit m_started = 0;
  int m_vline = 0;
  bit m_prev_cut = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  // Downstream ready: always, 1-0-0-1 pattern, or random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge video_clk); #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b1;
        1: begin
          m_axis_tready = (rdy_phase == 0) || (rdy_phase == 3);
          rdy_phase = (rdy_phase + 1) % 4;
        end
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Error pulse counters.
  always @(posedge video_clk) begin
    if (err_short === 1'b1) got_short++;
    if (err_long  === 1'b1) got_long++;
    if (err_sof   === 1'b1) got_sof++;
  end

  // Monitor: pops the scoreboard on each output handshake, checks stall holds.
  logic [DW+1:0] held;
  bit stall_prev = 0;
  always @(negedge video_clk) begin
    logic [DW+1:0] cur;
    logic [DW+1:0] expv;
    cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (mon_en) begin
      if (stall_prev) check("stall_hold", {m_axis_tvalid, cur}, {1'b1, held});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_beat: got %0h, required no beat", cur);
        end else begin
          expv = exp_q.pop_front();
          check("out_beat", cur, expv);
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = cur;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l,
                           input bit gaps, output int waits);
    waits = 0;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    forever begin
      @(negedge video_clk);
      if (s_axis_tready) break;
      waits++;
      if (waits > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL s_ready_timeout: waited %0d cycles, required <= 300", waits);
        break;
      end
      @(posedge video_clk); #1;
    end
    @(posedge video_clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    if (gaps) while ($urandom_range(0, 3) == 0) begin @(posedge video_clk); #1; end
  endtask

  // One input segment: a run of beats ending at TLAST (tl=1) or cut short by
  // the next frame's TUSER (tl=0). The model works per output line.
  task automatic send_seg(input bit u, input int len, input bit tl, input bit gaps,
                          output int first_wait);
    logic [DW-1:0] pix[$];
    int w;
    first_wait = 0;
    for (int i = 0; i < len; i++) pix.push_back(DW'($urandom));
    if (!m_started && u) begin
      m_started = 1; m_vline = 0; m_prev_cut = 0;
    end else if (m_started) begin
      if (u) begin
        if (m_prev_cut || m_vline != 0) exp_sof++;
        m_vline = 0;
      end else if (m_vline == 0) begin
        exp_sof++;
      end
    end
    if (m_started) begin
      for (int h = 0; h < H; h++)
        exp_q.push_back({(h == 0) && (m_vline == 0), h == H - 1, (h < len) ? pix[h] : PADV});
      if (len < H && tl) exp_short++;
      if (len > H || (len == H && !tl)) exp_long++;
      m_prev_cut = (len < H) && !tl;
      m_vline = (m_vline + 1) % V;
    end
    for (int i = 0; i < len; i++) begin
      send_beat(pix[i], (i == 0) && u, (i == len - 1) && tl, gaps, w);
      if (i == 0) first_wait = w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge video_clk); n++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (4) @(posedge video_clk);
    #1;
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_short"}, got_short, exp_short);
    check({tag, "_err_long"},  got_long,  exp_long);
    check({tag, "_err_sof"},   got_sof,   exp_sof);
  endtask

  task automatic clean_frame(input bit gaps);
    int w;
    for (int l = 0; l < V; l++) send_seg(l == 0, H, 1, gaps, w);
  endtask

  initial begin
    int w;
    int nl;
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #2;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tuser",  m_axis_tuser,  0);
    check("rst_m_tlast",  m_axis_tlast,  0);
    check("rst_m_tdata",  m_axis_tdata,  0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_locked",   locked,        0);
    check("rst_err_short", err_short,    0);
    check("rst_err_long",  err_long,     0);
    check("rst_err_sof",   err_sof,      0);
    repeat (3) @(posedge video_clk);
    #1 resetn = 1'b1;
    mon_en = 1;

    // Clean frame, then short/long lines, then a TUSER mid-line at (3,2).
    clean_frame(0);
    drain();
    check_errs("clean");
    check("locked_after_sof", locked, 1);
    send_seg(1, H, 1, 0, w);
    send_seg(0, 5, 1, 0, w);
    send_seg(0, 11, 1, 0, w);
    check("short_line_ready_low_cycles", w, 3);
    send_seg(0, H, 1, 0, w);
    send_seg(1, H, 1, 0, w);
    send_seg(0, H, 1, 0, w);
    send_seg(0, 3, 0, 0, w);
    clean_frame(0);
    drain();
    check_errs("directed");

    // Downstream stalls 1-0-0-1.
    rdy_mode = 1;
    clean_frame(0);
    drain();
    rdy_mode = 0;

    // Random line/frame lengths, random gaps and ready.
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(V - 1, V + 1);
      for (int l = 0; l < nl; l++)
        send_seg(l == 0, $urandom_range(1, H + 3),
                 (l != nl - 1) || ($urandom_range(0, 3) != 0), 1, w);
    end
    clean_frame(1);
    drain();
    rdy_mode = 0;
    check_errs("random");

    // Reset in the middle of a line.
    mon_en = 0;
    send_beat(24'h123456, 1, 0, 0, w);
    for (int i = 0; i < 3; i++) send_beat(DW'($urandom), 0, 0, 0, w);
    @(posedge video_clk); #3;
    resetn = 1'b0;
    #1;
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_m_tdata",  m_axis_tdata,  0);
    check("midrst_m_tuser",  m_axis_tuser,  0);
    check("midrst_m_tlast",  m_axis_tlast,  0);
    check("midrst_s_tready", s_axis_tready, 0);
    check("midrst_locked",   locked,        0);
    exp_q.delete();
    m_started = 0;
    repeat (2) @(posedge video_clk);
    #1 resetn = 1'b1;
    mon_en = 1;
    send_seg(0, 5, 1, 1, w);
    send_seg(0, 3, 1, 1, w);
    check("garbage_not_locked", locked, 0);
    clean_frame(1);
    drain();
    check_errs("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_line_conditioner.md
AXIS_LINE_CONDITIONER -- requirements
Module: axis_line_conditioner

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 24, pixel width (RGB888).
- H_ACTIVE, 1280, output beats per line.
- V_ACTIVE, 720, output lines per frame.
- PAD_PIXEL, 24'h000000, fill value for padded beats.
REQ-002 Ports SHALL be:
- video_clk  in  1  pixel clock; the block's single clock.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  pixel from VDMA.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  DATA_WIDTH  conditioned pixel to the video-out bridge.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  first beat of frame.
- m_axis_tlast  out  1  last beat of line.
- locked  out  1  high while in PASS, PAD or DROP.
- err_short  out  1  one-cycle pulse: input TLAST before H_ACTIVE beats.
- err_long  out  1  one-cycle pulse: H_ACTIVE beats without input TLAST.
- err_sof  out  1  one-cycle pulse: TUSER missing at frame start or arriving mid-frame.

Function
REQ-003 Output SHALL be exactly H_ACTIVE beats per line and V_ACTIVE lines per frame, whatever the input line and frame lengths.
REQ-004 m_axis_tuser SHALL be regenerated on output beat (h=0, v=0).
REQ-005 m_axis_tlast SHALL be regenerated on output beat h=H_ACTIVE-1.
REQ-006 Output SHALL be a single register stage.
- Latency from accepted input beat to m_axis_tvalid is 1 cycle.
- While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs are held stable.
REQ-007 h_cnt and v_cnt SHALL advance only on an output handshake.
- Widths are $clog2(H_ACTIVE) and $clog2(V_ACTIVE).
- h_cnt wraps to 0 after H_ACTIVE-1, then v_cnt increments.
- v_cnt wraps to 0 after V_ACTIVE-1.
REQ-008 States SHALL be SEEK_SOF, PASS, PAD and DROP. Reset enters SEEK_SOF.
REQ-009 SEEK_SOF:
- s_axis_tready=1; non-TUSER beats are discarded.
- The first TUSER beat loads the output register as (h=0, v=0), then the state goes to PASS.
REQ-010 PASS: s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-011 PASS, input TLAST on a beat with h<H_ACTIVE-1:
- The beat is forwarded, err_short pulses, and the state goes to PAD.
REQ-012 PAD:
- s_axis_tready=0.
- The block emits PAD_PIXEL beats until the beat at h=H_ACTIVE-1 is handshaken, then returns to PASS.
REQ-013 PASS, beat at h=H_ACTIVE-1 without TLAST:
- The beat is forwarded with m_axis_tlast=1, err_long pulses, and the state goes to DROP.
REQ-014 DROP:
- s_axis_tready=1 and beats are discarded through the input TLAST beat inclusive, then the state returns to PASS.
- A TUSER beat in DROP is not consumed; the block exits to PASS as a frame restart (REQ-015).
REQ-015 Input TUSER with (h,v)≠(0,0) in PASS SHALL NOT be consumed; the block SHALL:
- pulse err_sof;
- pad the current line if h≠0;
- force v_cnt=0;
- accept the TUSER beat as the new (0,0) beat.
REQ-016 At (h=0, v=0) in PASS, an input beat without TUSER SHALL be forwarded with regenerated m_axis_tuser=1, and err_sof SHALL pulse.
REQ-017 Input TLAST together with TUSER on one beat SHALL be treated as TUSER first, then as a 1-beat short line (err_sof and err_short both pulse).
REQ-018 Input TLAST on the beat at h=H_ACTIVE-1 SHALL be normal: no error pulses, and the state stays PASS.

Reset
REQ-019 While resetn=0, independent of video_clk, the block SHALL force:
- state=SEEK_SOF;
- h_cnt=0 and v_cnt=0;
- m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata = 0;
- s_axis_tready=0;
- locked=0 and all err_* = 0.
REQ-020 Deassertion of resetn SHALL take effect synchronously to video_clk, through a 2-flop synchronizer.
REQ-021 Reset mid-frame SHALL discard the held output beat; after release the block resumes in SEEK_SOF.

Structure
REQ-022 The state encoding and the default H_ACTIVE, V_ACTIVE and DATA_WIDTH constants SHALL live in the shared video package, which is reused by the video-out bridge.
REQ-023 The output register SHALL be one sub-module, axis_reg_slice, parameterised by DATA_WIDTH+2.

Verification (bench uses H_ACTIVE=8, V_ACTIVE=4, PAD_PIXEL=24'hFFFFFF)
REQ-024 Clean 4x8 frame with TUSER/TLAST, m_axis_tready=1 -> 32 beats, data identical, tuser on beat 0, tlast on beats 7/15/23/31, no err pulses.
REQ-025 Line 1 of 5 beats -> 5 data beats then 3 beats of FFFFFF, tlast on the 8th beat, err_short pulse x1, s_axis_tready=0 for 3 cycles.
REQ-026 Line 2 of 11 beats -> 8 beats forwarded, 3 dropped, err_long x1, next line starts with input beat 12.
REQ-027 TUSER at (h=3, v=2) -> 5 PAD beats, err_sof x1, next output beat is the TUSER pixel with m_axis_tuser=1.
REQ-028 m_axis_tready toggled 1-0-0-1 on a clean frame -> m_axis_* stable during stalls, no loss or duplication; resetn pulsed low mid-line -> all outputs 0 immediately, then garbage dropped until next TUSER.
